// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the two-port memory arbiter:
//   - memory command encoding (MEM_NONE / MEM_READ / MEM_WRITE)
//   - arbiter FSM state encoding (IDLE / ACCESS / DONE, 2 bits)
//   - default address / data widths (512 x 16 RAM)
//   - is_req(): a command counts as a request only for read or write
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int AW_DEF = 9;
    localparam int DW_DEF = 16;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } arb_state_e;

    // cmd 11 is deliberately treated the same as "no request".
    function automatic logic is_req(input logic [1:0] cmd);
        return (cmd == MEM_READ) || (cmd == MEM_WRITE);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// One memory-access channel: command, word address, write data, read data
// and an access-complete pulse. Used for both requester ports and for the
// RAM side of the arbiter.
//   master : drives cmd/addr/wdata, receives rdata/ready (a requester, or
//            the arbiter towards the RAM)
//   slave  : receives cmd/addr/wdata, drives rdata/ready (the arbiter
//            towards a requester, or the RAM)
// On the RAM channel ready is not used by the arbiter.
// ---------------------------------------------------------------------------
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic [1:0]    cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          ready;

    modport master (output cmd, output addr, output wdata, input rdata, input ready);
    modport slave  (input cmd, input addr, input wdata, output rdata, output ready);
endinterface

// File: rtl/mem_arb_pick.sv
// ---------------------------------------------------------------------------
// mem_arb_pick
// Combinational winner selection for the arbiter.
// Ports:
//   req0, req1  : port 0 / port 1 has a valid request (read or write)
//   prefer_p1   : (MEM_ARB_RR_EN only) port 1 wins the next tie
//   winner      : one-hot winner, 2'b00 when nobody requests
// Build option MEM_ARB_RR_EN: round-robin on ties; otherwise port 0 (CPU)
// always wins a tie and no pointer input exists.
// ---------------------------------------------------------------------------
module mem_arb_pick (
    input  logic       req0,
    input  logic       req1,
`ifdef MEM_ARB_RR_EN
    input  logic       prefer_p1,
`endif
    output logic [1:0] winner
);

    // Tie resolution is the only place the two builds differ.
    always_comb begin
        winner = 2'b00;
        if (req0 && req1) begin
`ifdef MEM_ARB_RR_EN
            if (prefer_p1) begin
                winner = 2'b10;
            end else begin
                winner = 2'b01;
            end
`else
            winner = 2'b01;
`endif
        end else if (req0) begin
            winner = 2'b01;
        end else if (req1) begin
            winner = 2'b10;
        end else begin
            winner = 2'b00;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares a single-ported synchronous RAM between port 0 (CPU) and port 1
// (DMA / loader). One access at a time, sequenced IDLE -> ACCESS -> DONE:
// the request is sampled in IDLE, the RAM command is driven during ACCESS,
// and the winner gets a one-cycle ready (plus read data) during DONE.
// Ports:
//   clk, reset : clock (rising edge), asynchronous active-high reset
//   p0, p1     : requester channels (slave side)
//   mem        : RAM channel (master side); rdata valid the cycle after a read
//   grant      : one-hot owner of the current access, 00 when idle
//   busy       : high in ACCESS and DONE
// Build option MEM_ARB_RR_EN: round-robin tie-break with a one-bit pointer;
// without it port 0 wins every tie.
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave  p0,
    mem_arbiter_if.slave  p1,
    mem_arbiter_if.master mem,
    output logic [1:0]   grant,
    output logic         busy
);

    arb_state_e    state_r;
    logic [1:0]    cmd_r;
    logic [1:0]    grant_r;
    logic          busy_r;
    logic [1:0]    mem_cmd_r;
    logic [AW-1:0] mem_addr_r;
    logic [DW-1:0] mem_wdata_r;
    logic          ready0_r;
    logic          ready1_r;
    logic [DW-1:0] rdata0_r;
    logic [DW-1:0] rdata1_r;
    logic          req0_s;
    logic          req1_s;
    logic [1:0]    win_s;
`ifdef MEM_ARB_RR_EN
    logic          prefer_p1_r;
`endif

    assign req0_s = is_req(p0.cmd);
    assign req1_s = is_req(p1.cmd);

    mem_arb_pick u_pick (
        .req0      (req0_s),
        .req1      (req1_s),
`ifdef MEM_ARB_RR_EN
        .prefer_p1 (prefer_p1_r),
`endif
        .winner    (win_s)
    );

    // Arbitration FSM: latches the winning request, drives the RAM during
    // ACCESS and issues ready during DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cmd_r       <= MEM_NONE;
            grant_r     <= 2'b00;
            busy_r      <= 1'b0;
            mem_cmd_r   <= MEM_NONE;
            mem_addr_r  <= {AW{1'b0}};
            mem_wdata_r <= {DW{1'b0}};
            ready0_r    <= 1'b0;
            ready1_r    <= 1'b0;
            rdata0_r    <= {DW{1'b0}};
            rdata1_r    <= {DW{1'b0}};
`ifdef MEM_ARB_RR_EN
            prefer_p1_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ready0_r <= 1'b0;
                    ready1_r <= 1'b0;
                    // The memory outputs double as the latched address and
                    // write data; cmd_r keeps the command for DONE.
                    if (win_s[0]) begin
                        state_r     <= ST_ACCESS;
                        grant_r     <= 2'b01;
                        busy_r      <= 1'b1;
                        cmd_r       <= p0.cmd;
                        mem_cmd_r   <= p0.cmd;
                        mem_addr_r  <= p0.addr;
                        mem_wdata_r <= p0.wdata;
`ifdef MEM_ARB_RR_EN
                        prefer_p1_r <= 1'b1;
`endif
                    end else if (win_s[1]) begin
                        state_r     <= ST_ACCESS;
                        grant_r     <= 2'b10;
                        busy_r      <= 1'b1;
                        cmd_r       <= p1.cmd;
                        mem_cmd_r   <= p1.cmd;
                        mem_addr_r  <= p1.addr;
                        mem_wdata_r <= p1.wdata;
`ifdef MEM_ARB_RR_EN
                        prefer_p1_r <= 1'b0;
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    state_r     <= ST_DONE;
                    mem_cmd_r   <= MEM_NONE;
                    mem_addr_r  <= {AW{1'b0}};
                    mem_wdata_r <= {DW{1'b0}};
                    ready0_r    <= grant_r[0];
                    ready1_r    <= grant_r[1];
                end
                ST_DONE: begin
                    state_r  <= ST_IDLE;
                    grant_r  <= 2'b00;
                    busy_r   <= 1'b0;
                    ready0_r <= 1'b0;
                    ready1_r <= 1'b0;
                    // Keep the read word so rdata holds after ready drops.
                    if (cmd_r == MEM_READ) begin
                        if (grant_r[0]) begin
                            rdata0_r <= mem.rdata;
                        end else if (grant_r[1]) begin
                            rdata1_r <= mem.rdata;
                        end else begin
                            rdata0_r <= rdata0_r;
                        end
                    end else begin
                        rdata0_r <= rdata0_r;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    grant_r     <= 2'b00;
                    busy_r      <= 1'b0;
                    mem_cmd_r   <= MEM_NONE;
                    mem_addr_r  <= {AW{1'b0}};
                    mem_wdata_r <= {DW{1'b0}};
                    ready0_r    <= 1'b0;
                    ready1_r    <= 1'b0;
                end
            endcase
        end
    end

    assign mem.cmd   = mem_cmd_r;
    assign mem.addr  = mem_addr_r;
    assign mem.wdata = mem_wdata_r;
    assign grant     = grant_r;
    assign busy      = busy_r;
    assign p0.ready  = ready0_r;
    assign p1.ready  = ready1_r;

    // The synchronous RAM only presents the word during DONE, so the winner
    // sees it directly while ready is high; otherwise the held copy is shown.
    assign p0.rdata = (ready0_r && (cmd_r == MEM_READ)) ? mem.rdata : rdata0_r;
    assign p1.rdata = (ready1_r && (cmd_r == MEM_READ)) ? mem.rdata : rdata1_r;

endmodule
